contador_garrafas: RTL and testbench
====================================

CONTADOR_GARRAFAS -- requirements
Module: contador_garrafas

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000 (1 ms at 50 MHz), is the stable-input time required before the debounced sensor changes.
REQ-002 Parameter GARRAFAS_POR_DUZIA, default 4'd12, is the bottle count per dozen.
REQ-003 Parameter TIMEOUT_CYCLES, default 27'd100000000 (2 s), is the maximum debounced-high time before a jam is flagged.
REQ-004 clk  input  1  50 MHz system clock; only clock.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 sensor_final  input  1  raw, asynchronous final-position bottle sensor; 1 means bottle present.
REQ-007 habilitar  input  1  conveyor running; bottles count only while 1.
REQ-008 reset_manual  input  1  one-cycle START pulse (KEY0, already pulsed), clears count and jam flag.
REQ-009 sensor_estavel  output  1  synchronized, debounced sensor level.
REQ-010 garrafas_valor  output  4  bottles counted in the current dozen, range 0..GARRAFAS_POR_DUZIA-1.
REQ-011 duzia_completa  output  1  one-cycle pulse per completed dozen; drives the dozen counter's incrementar input.
REQ-012 erro_sensor  output  1  sticky jam flag.

Function
REQ-013 sensor_final shall pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: a 16-bit counter shall increment each cycle the synchronized input differs from sensor_estavel and clear on any cycle they agree.
REQ-015 sensor_estavel shall toggle, and its counter shall clear, in the cycle the counter reaches DEBOUNCE_CYCLES-1 while inputs still differ.
REQ-016 Latency: a clean input step reaches sensor_estavel exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall not change sensor_estavel.
REQ-018 Bottle event: the cycle sensor_estavel is 1 and was 0 in the previous cycle; falling edges are ignored.
REQ-019 Counting: a bottle event with habilitar=1 shall update garrafas_valor on the next clock edge.
REQ-020 Counting rule: if garrafas_valor = GARRAFAS_POR_DUZIA-1, wrap to 0; otherwise increment by 1.
REQ-021 A bottle event with habilitar=0 shall be discarded, not deferred.
REQ-022 duzia_completa shall be 1 exactly in the cycle garrafas_valor shows the wrap to 0, and 0 in all other cycles.
REQ-023 Jam timer: a 27-bit counter shall count cycles with sensor_estavel=1 and clear when sensor_estavel=0.
REQ-024 erro_sensor shall set on the cycle the jam counter reaches TIMEOUT_CYCLES-1, and the counter shall saturate there.
REQ-025 erro_sensor shall remain 1 until reset_manual or reset; counting continues while it is set.
REQ-026 reset_manual shall clear garrafas_valor, duzia_completa, erro_sensor and the jam counter on the next edge.
REQ-027 reset_manual shall not disturb the synchronizer, the debounce state or sensor_estavel.
REQ-028 A bottle event in the same cycle as reset_manual shall be lost; reset_manual wins.
REQ-029 If reset_manual is applied while sensor_estavel=1, the jam counter shall restart from 0 and erro_sensor may set again after a further TIMEOUT_CYCLES.

Reset
REQ-030 While reset=0 at a clock edge, all of the following shall be 0 on that edge: synchronizer flops, debounce counter, sensor_estavel, edge-detect history, garrafas_valor, duzia_completa, jam counter and erro_sensor.
REQ-031 reset has priority over reset_manual and all other inputs.
REQ-032 Reset applied mid-debounce or mid-count shall discard the partial state; no bottle event shall be produced on release.
REQ-033 After release, a sensor already high shall count once it has been debounced.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-034 Clean pulse: sensor_final high for 10 cycles with habilitar=1 -> sensor_estavel rises 6 clocks after the first sampling edge; garrafas_valor goes 0->1 one clock later.
REQ-035 Glitch: sensor_final high for 3 cycles -> sensor_estavel stays 0 and garrafas_valor stays 0.
REQ-036 Dozen wrap: 12 clean bottles -> garrafas_valor reads 11 then 0, with duzia_completa=1 for exactly that one cycle; 24 bottles -> exactly 2 pulses.
REQ-037 Gating and collision:
- a bottle with habilitar=0 leaves the count unchanged;
- a bottle event coincident with reset_manual at count 5 -> count 0 and no increment.
REQ-038 Jam: sensor_final held high for 60 cycles -> erro_sensor=1 exactly 50 cycles after sensor_estavel rises and stays 1 after the sensor drops; reset_manual -> erro_sensor=0.
REQ-039 Reset mid-operation: reset=0 for 1 cycle at count 7 with debounce in progress -> all outputs 0 on that edge, and the next clean bottle gives count 1.

Source files
------------

// File: rtl/contador_garrafas.sv
// Bottle counter for the end-of-line sensor: synchronizes and debounces the raw
// sensor, counts rising edges into dozens and flags a jammed (stuck-high) sensor.
module contador_garrafas #(
    parameter logic [15:0] DEBOUNCE_CYCLES    = 16'd50000,
    parameter logic [3:0]  GARRAFAS_POR_DUZIA = 4'd12,
    parameter logic [26:0] TIMEOUT_CYCLES     = 27'd100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_final,
    input  logic       habilitar,
    input  logic       reset_manual,
    output logic       sensor_estavel,
    output logic [3:0] garrafas_valor,
    output logic       duzia_completa,
    output logic       erro_sensor
);

    logic        sync1_r;
    logic        sync2_r;
    logic [15:0] deb_cnt_r;
    logic        estavel_r;
    logic        hist_r;
    logic [3:0]  valor_r;
    logic        duzia_r;
    logic [26:0] jam_cnt_r;
    logic        erro_r;

    logic [15:0] deb_cnt_s;
    logic        estavel_s;
    logic        evento_s;
    logic [3:0]  valor_s;
    logic        duzia_s;
    logic [26:0] jam_cnt_s;
    logic        erro_s;

    // Debounce: the stable level flips only after the input has disagreed long enough
    always_comb begin
        deb_cnt_s = 16'd0;
        estavel_s = estavel_r;
        if (sync2_r != estavel_r) begin
            if (deb_cnt_r == (DEBOUNCE_CYCLES - 16'd1)) begin
                estavel_s = ~estavel_r;
                deb_cnt_s = 16'd0;
            end else begin
                deb_cnt_s = deb_cnt_r + 16'd1;
            end
        end else begin
            deb_cnt_s = 16'd0;
        end
    end

    // Bottle counting; the manual START clears the count and drops a coincident event
    always_comb begin
        evento_s = estavel_r & ~hist_r;
        valor_s  = valor_r;
        duzia_s  = 1'b0;
        if (reset_manual) begin
            valor_s = 4'd0;
        end else if (evento_s && habilitar) begin
            if (valor_r == (GARRAFAS_POR_DUZIA - 4'd1)) begin
                valor_s = 4'd0;
                duzia_s = 1'b1;
            end else begin
                valor_s = valor_r + 4'd1;
            end
        end else begin
            valor_s = valor_r;
        end
    end

    // Jam timer saturates at its limit; the error flag is sticky until START or reset
    always_comb begin
        jam_cnt_s = jam_cnt_r;
        erro_s    = erro_r;
        if (reset_manual) begin
            jam_cnt_s = 27'd0;
            erro_s    = 1'b0;
        end else if (estavel_r) begin
            if (jam_cnt_r == (TIMEOUT_CYCLES - 27'd1)) begin
                erro_s = 1'b1;
            end else begin
                jam_cnt_s = jam_cnt_r + 27'd1;
            end
        end else begin
            jam_cnt_s = 27'd0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            deb_cnt_r <= 16'd0;
            estavel_r <= 1'b0;
            hist_r    <= 1'b0;
            valor_r   <= 4'd0;
            duzia_r   <= 1'b0;
            jam_cnt_r <= 27'd0;
            erro_r    <= 1'b0;
        end else begin
            sync1_r   <= sensor_final;
            sync2_r   <= sync1_r;
            deb_cnt_r <= deb_cnt_s;
            estavel_r <= estavel_s;
            hist_r    <= estavel_r;
            valor_r   <= valor_s;
            duzia_r   <= duzia_s;
            jam_cnt_r <= jam_cnt_s;
            erro_r    <= erro_s;
        end
    end

    assign sensor_estavel = estavel_r;
    assign garrafas_valor = valor_r;
    assign duzia_completa = duzia_r;
    assign erro_sensor    = erro_r;

endmodule

// File: tb/tb_contador_garrafas.sv
// Directed bench for contador_garrafas with short debounce and jam timeouts.
module tb_contador_garrafas;

    logic       clk;
    logic       reset;
    logic       sensor_final;
    logic       habilitar;
    logic       reset_manual;
    logic       sensor_estavel;
    logic [3:0] garrafas_valor;
    logic       duzia_completa;
    logic       erro_sensor;

    int n_checks;
    int n_fail;
    int pulses;

    contador_garrafas #(
        .DEBOUNCE_CYCLES(16'd4),
        .GARRAFAS_POR_DUZIA(4'd12),
        .TIMEOUT_CYCLES(27'd50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sensor_final(sensor_final),
        .habilitar(habilitar),
        .reset_manual(reset_manual),
        .sensor_estavel(sensor_estavel),
        .garrafas_valor(garrafas_valor),
        .duzia_completa(duzia_completa),
        .erro_sensor(erro_sensor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200 us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bottle();
        sensor_final = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (duzia_completa) pulses++;
        end
        sensor_final = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (duzia_completa) pulses++;
        end
    endtask

    task automatic start_pulse();
        reset_manual = 1'b1;
        tick();
        reset_manual = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (sensor_estavel !== 1'b0) begin n_fail++; $display("FAIL reset_estavel: got %0b expected 0", sensor_estavel); end
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL reset_valor: got %0d expected 0", garrafas_valor); end
        n_checks++; if (duzia_completa !== 1'b0) begin n_fail++; $display("FAIL reset_duzia: got %0b expected 0", duzia_completa); end
        n_checks++; if (erro_sensor !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %0b expected 0", erro_sensor); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_clean_pulse();
        sensor_final = 1'b1;
        repeat (5) tick();
        n_checks++; if (sensor_estavel !== 1'b0) begin n_fail++; $display("FAIL clean_est_early: got %0b expected 0", sensor_estavel); end
        tick();
        n_checks++; if (sensor_estavel !== 1'b1) begin n_fail++; $display("FAIL clean_est_rise: got %0b expected 1", sensor_estavel); end
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL clean_valor_before: got %0d expected 0", garrafas_valor); end
        tick();
        n_checks++; if (garrafas_valor !== 4'd1) begin n_fail++; $display("FAIL clean_valor_after: got %0d expected 1", garrafas_valor); end
        repeat (3) tick();
        sensor_final = 1'b0;
        repeat (10) tick();
        n_checks++; if (garrafas_valor !== 4'd1) begin n_fail++; $display("FAIL clean_valor_hold: got %0d expected 1", garrafas_valor); end
    endtask

    task automatic test_glitch();
        logic saw_high;
        start_pulse();
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL glitch_start_clear: got %0d expected 0", garrafas_valor); end
        saw_high = 1'b0;
        sensor_final = 1'b1;
        repeat (3) begin tick(); if (sensor_estavel) saw_high = 1'b1; end
        sensor_final = 1'b0;
        repeat (12) begin tick(); if (sensor_estavel) saw_high = 1'b1; end
        n_checks++; if (saw_high !== 1'b0) begin n_fail++; $display("FAIL glitch_estavel: got %0b expected 0", saw_high); end
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL glitch_valor: got %0d expected 0", garrafas_valor); end
    endtask

    task automatic test_dozen();
        start_pulse();
        pulses = 0;
        for (int b = 0; b < 11; b++) send_bottle();
        n_checks++; if (garrafas_valor !== 4'd11) begin n_fail++; $display("FAIL dozen_eleven: got %0d expected 11", garrafas_valor); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL dozen_early_pulse: got %0d expected 0", pulses); end
        sensor_final = 1'b1;
        repeat (6) tick();
        n_checks++; if (garrafas_valor !== 4'd11) begin n_fail++; $display("FAIL dozen_pre_wrap: got %0d expected 11", garrafas_valor); end
        n_checks++; if (duzia_completa !== 1'b0) begin n_fail++; $display("FAIL dozen_pre_pulse: got %0b expected 0", duzia_completa); end
        tick();
        if (duzia_completa) pulses++;
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL dozen_wrap: got %0d expected 0", garrafas_valor); end
        n_checks++; if (duzia_completa !== 1'b1) begin n_fail++; $display("FAIL dozen_pulse: got %0b expected 1", duzia_completa); end
        tick();
        if (duzia_completa) pulses++;
        n_checks++; if (duzia_completa !== 1'b0) begin n_fail++; $display("FAIL dozen_pulse_width: got %0b expected 0", duzia_completa); end
        repeat (2) tick();
        sensor_final = 1'b0;
        repeat (10) tick();
        for (int b = 0; b < 12; b++) send_bottle();
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL dozen_24_pulses: got %0d expected 2", pulses); end
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL dozen_24_valor: got %0d expected 0", garrafas_valor); end
    endtask

    task automatic test_gating();
        start_pulse();
        send_bottle();
        send_bottle();
        n_checks++; if (garrafas_valor !== 4'd2) begin n_fail++; $display("FAIL gate_base: got %0d expected 2", garrafas_valor); end
        habilitar = 1'b0;
        send_bottle();
        n_checks++; if (garrafas_valor !== 4'd2) begin n_fail++; $display("FAIL gate_disabled: got %0d expected 2", garrafas_valor); end
        habilitar = 1'b1;
        repeat (3) tick();
        n_checks++; if (garrafas_valor !== 4'd2) begin n_fail++; $display("FAIL gate_not_deferred: got %0d expected 2", garrafas_valor); end
    endtask

    task automatic test_collision();
        start_pulse();
        for (int b = 0; b < 5; b++) send_bottle();
        n_checks++; if (garrafas_valor !== 4'd5) begin n_fail++; $display("FAIL coll_base: got %0d expected 5", garrafas_valor); end
        sensor_final = 1'b1;
        repeat (6) tick();
        reset_manual = 1'b1;
        tick();
        reset_manual = 1'b0;
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL coll_clear: got %0d expected 0", garrafas_valor); end
        tick();
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL coll_lost: got %0d expected 0", garrafas_valor); end
        repeat (2) tick();
        sensor_final = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_jam();
        int n;
        int m;
        start_pulse();
        sensor_final = 1'b1;
        n = 0;
        while (sensor_estavel == 1'b0 && n < 20) begin tick(); n++; end
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL jam_rise_latency: got %0d expected 6", n); end
        m = 0;
        while (erro_sensor == 1'b0 && m < 100) begin tick(); m++; end
        n_checks++; if (m !== 50) begin n_fail++; $display("FAIL jam_timeout: got %0d expected 50", m); end
        repeat (4) tick();
        sensor_final = 1'b0;
        repeat (10) tick();
        n_checks++; if (sensor_estavel !== 1'b0) begin n_fail++; $display("FAIL jam_est_drop: got %0b expected 0", sensor_estavel); end
        n_checks++; if (erro_sensor !== 1'b1) begin n_fail++; $display("FAIL jam_sticky: got %0b expected 1", erro_sensor); end
        start_pulse();
        n_checks++; if (erro_sensor !== 1'b0) begin n_fail++; $display("FAIL jam_clear: got %0b expected 0", erro_sensor); end
    endtask

    task automatic test_reset_mid();
        logic saw_high;
        start_pulse();
        for (int b = 0; b < 7; b++) send_bottle();
        n_checks++; if (garrafas_valor !== 4'd7) begin n_fail++; $display("FAIL mid_base: got %0d expected 7", garrafas_valor); end
        sensor_final = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        sensor_final = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++; if (garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL mid_valor: got %0d expected 0", garrafas_valor); end
        n_checks++; if (sensor_estavel !== 1'b0) begin n_fail++; $display("FAIL mid_estavel: got %0b expected 0", sensor_estavel); end
        n_checks++; if ({duzia_completa, erro_sensor} !== 2'b00) begin n_fail++; $display("FAIL mid_flags: got %0b expected 0", {duzia_completa, erro_sensor}); end
        saw_high = 1'b0;
        repeat (10) begin tick(); if (sensor_estavel) saw_high = 1'b1; end
        n_checks++; if (saw_high !== 1'b0 || garrafas_valor !== 4'd0) begin n_fail++; $display("FAIL mid_release: got est %0b valor %0d expected 0 0", saw_high, garrafas_valor); end
        send_bottle();
        n_checks++; if (garrafas_valor !== 4'd1) begin n_fail++; $display("FAIL mid_next_bottle: got %0d expected 1", garrafas_valor); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        pulses       = 0;
        reset        = 1'b0;
        sensor_final = 1'b0;
        habilitar    = 1'b1;
        reset_manual = 1'b0;
        test_reset();
        test_clean_pulse();
        test_glitch();
        test_dozen();
        test_gating();
        test_collision();
        test_jam();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
